// File: rtl/riscv_test_pkg.sv
// ============================================================================
// riscv_test_pkg : shared state encoding and register indices for the
//                  rv32ui pass/fail write-back monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_test_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam int DEF_TESTNUM_REG = 3;
  localparam int DEF_DONE_REG    = 26;
  localparam int DEF_RESULT_REG  = 27;

  localparam logic [DATA_W-1:0] PASS_VALUE = 32'd1;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  function automatic logic is_live(input state_e s);
    return (s == ST_RUN) || (s == ST_SETTLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_test_monitor_wb_shadow_reg.sv
// ============================================================================
// wb_shadow_reg : shadows one architectural register from the write-back port
//                 and forwards a same-cycle write as the effective value
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_shadow_reg
  import riscv_test_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic [DATA_W-1:0]     eff_o
);

  logic                  hit;
  logic [DATA_W-1:0]     value_q;

  // x0 is hard-wired zero in the core, so a write to it never lands anywhere
  assign hit = wb_en_i && (wb_addr_i == REG_ADDR_W'(IDX)) &&
               (wb_addr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (hit && !freeze_i) begin
      value_q <= wb_data_i;
    end
  end

  assign eff_o = hit ? wb_data_i : value_q;

endmodule

`default_nettype wire

// File: rtl/riscv_test_monitor.sv
// ============================================================================
// riscv_test_monitor : watches register-file write-backs and reports
//                      PASS / FAIL / TIMEOUT for rv32ui-p-* programs
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int DONE_REG       = DEF_DONE_REG,
  parameter int RESULT_REG     = DEF_RESULT_REG,
  parameter int TESTNUM_REG    = DEF_TESTNUM_REG,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [DATA_W-1:0]     fail_test_num
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [DATA_W-1:0]  ftn_q, ftn_d;
  logic               done_q, pass_q, fail_q, timeout_q;

  logic               live;
  logic               frozen;
  logic               done_wr;
  logic               at_timeout;
  logic [DATA_W-1:0]  tn_eff;
  logic [DATA_W-1:0]  res_eff;
  logic [DATA_W-1:0]  done_eff;

  assign live   = is_live(state_q);
  assign frozen = !live;

  wb_shadow_reg #(.IDX(TESTNUM_REG)) u_testnum (
    .clk       (clk),
    .rst_n     (rst),
    .freeze_i  (frozen),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .eff_o     (tn_eff)
  );

  wb_shadow_reg #(.IDX(RESULT_REG)) u_result (
    .clk       (clk),
    .rst_n     (rst),
    .freeze_i  (frozen),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .eff_o     (res_eff)
  );

  wb_shadow_reg #(.IDX(DONE_REG)) u_done (
    .clk       (clk),
    .rst_n     (rst),
    .freeze_i  (frozen),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .eff_o     (done_eff)
  );

  // The forwarded value equals wb_data exactly when this cycle hits DONE_REG
  assign done_wr    = wb_en && (wb_addr == REG_ADDR_W'(DONE_REG)) &&
                      (done_eff == PASS_VALUE);
  assign at_timeout = (cycle_q == TIMEOUT_LAST);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cycle_d  = cycle_q;
    ftn_d    = ftn_q;

    if (live && (cycle_q != '1)) begin
      cycle_d = cycle_q + 1'b1;
    end

    // Done write and settle expiry take priority over a coincident timeout
    case (state_q)
      ST_RUN: begin
        if (done_wr) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (at_timeout) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) begin
          state_d = (res_eff == PASS_VALUE) ? ST_PASS : ST_FAIL;
        end else if (at_timeout) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: begin
      end
    endcase

    if (live && ((state_d == ST_FAIL) || (state_d == ST_TIMEOUT))) begin
      ftn_d = tn_eff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      settle_q  <= '0;
      cycle_q   <= '0;
      ftn_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      cycle_q   <= cycle_d;
      ftn_q     <= ftn_d;
      done_q    <= !is_live(state_d);
      pass_q    <= (state_d == ST_PASS);
      fail_q    <= (state_d == ST_FAIL);
      timeout_q <= (state_d == ST_TIMEOUT);
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_q;
  assign fail_test_num = ftn_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
// ============================================================================
// tb_riscv_test_monitor : table, directed and randomized checks of the
//                         write-back pass/fail monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_riscv_test_monitor;

  localparam int SETTLE = 2;
  localparam int TO_A   = 200;
  localparam int TO_B   = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     = 1'b0;
  logic        wb_en   = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  logic        a_done, a_pass, a_fail, a_to;
  logic [31:0] a_cnt, a_ftn;
  logic        b_done, b_pass, b_fail, b_to;
  logic [31:0] b_cnt, b_ftn;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_test_monitor #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO_A), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_to),
    .cycle_count(a_cnt), .fail_test_num(a_ftn)
  );

  riscv_test_monitor #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO_B), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_to),
    .cycle_count(b_cnt), .fail_test_num(b_ftn)
  );

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [67:0] exp;
  } vec_t;
  vec_t tbl [8];

  // Reference: edges counted since reset release; verdict fixed SETTLE edges after the done edge
  typedef struct {
    int          n;
    bit          seen;
    int          done_edge;
    int          verdict;   // 0 none, 1 pass, 2 fail, 3 timeout
    logic [31:0] sh_tn;
    logic [31:0] sh_res;
    logic [31:0] ftn;
  } mdl_t;
  mdl_t mdl [2];
  int   tmo [2];

  function automatic logic [67:0] pk(input logic d, input logic p, input logic f,
                                     input logic t, input logic [31:0] c,
                                     input logic [31:0] ftn);
    return {d, p, f, t, c, ftn};
  endfunction

  function automatic logic [67:0] out_a();
    return {a_done, a_pass, a_fail, a_to, a_cnt, a_ftn};
  endfunction

  function automatic logic [67:0] out_b();
    return {b_done, b_pass, b_fail, b_to, b_cnt, b_ftn};
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got d/p/f/t=%b cnt=%0d ftn=%0d, expected d/p/f/t=%b cnt=%0d ftn=%0d",
               name, act[67:64], act[63:32], act[31:0], exp[67:64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic model_reset(input int i);
    mdl[i].n = 0; mdl[i].seen = 1'b0; mdl[i].done_edge = 0; mdl[i].verdict = 0;
    mdl[i].sh_tn = '0; mdl[i].sh_res = '0; mdl[i].ftn = '0;
  endtask

  task automatic model_edge(input int i, input logic en, input logic [4:0] addr,
                            input logic [31:0] data);
    logic [31:0] e_tn, e_res;
    if (mdl[i].verdict == 0) begin
      mdl[i].n++;
      e_tn  = (en && addr == 5'd3)  ? data : mdl[i].sh_tn;
      e_res = (en && addr == 5'd27) ? data : mdl[i].sh_res;
      if (!mdl[i].seen && en && addr == 5'd26 && data == 32'd1) begin
        mdl[i].seen = 1'b1;
        mdl[i].done_edge = mdl[i].n;
      end else if (mdl[i].seen && mdl[i].n == mdl[i].done_edge + SETTLE) begin
        mdl[i].verdict = (e_res == 32'd1) ? 1 : 2;
      end else if (mdl[i].n == tmo[i]) begin
        mdl[i].verdict = 3;
      end
      if (mdl[i].verdict >= 2) mdl[i].ftn = e_tn;
      mdl[i].sh_tn  = e_tn;
      mdl[i].sh_res = e_res;
    end
  endtask

  function automatic logic [67:0] model_exp(input int i);
    return pk(mdl[i].verdict != 0, mdl[i].verdict == 1, mdl[i].verdict == 2,
              mdl[i].verdict == 3, 32'(mdl[i].n), mdl[i].ftn);
  endfunction

  task automatic step(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
    @(posedge clk);
    #1;
    model_edge(0, en, addr, data);
    model_edge(1, en, addr, data);
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rst = 1'b0;
    #1;
    check("reset_a", out_a(), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
  endtask

  initial begin
    logic        re;
    logic [4:0]  ra;
    logic [31:0] rd;
    int          len, r;

    tmo[0] = TO_A;
    tmo[1] = TO_B;

    tbl[0] = '{1'b1, 5'd3,  32'd7, pk(0, 0, 0, 0, 32'd1, 32'd0)};
    tbl[1] = '{1'b1, 5'd27, 32'd0, pk(0, 0, 0, 0, 32'd2, 32'd0)};
    tbl[2] = '{1'b1, 5'd26, 32'd1, pk(0, 0, 0, 0, 32'd3, 32'd0)};
    tbl[3] = '{1'b0, 5'd0,  32'd0, pk(0, 0, 0, 0, 32'd4, 32'd0)};
    tbl[4] = '{1'b1, 5'd0,  32'd1, pk(1, 0, 1, 0, 32'd5, 32'd7)};
    tbl[5] = '{1'b1, 5'd3,  32'd9, pk(1, 0, 1, 0, 32'd5, 32'd7)};
    tbl[6] = '{1'b1, 5'd26, 32'd1, pk(1, 0, 1, 0, 32'd5, 32'd7)};
    tbl[7] = '{1'b0, 5'd0,  32'd0, pk(1, 0, 1, 0, 32'd5, 32'd7)};

    // Fail sequence from the table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].addr, tbl[i].data);
      check($sformatf("tbl%0d", i), out_a(), tbl[i].exp);
    end

    // Done-then-pass: done at edge 12, verdict at 14
    do_reset();
    step(1'b1, 5'd27, 32'd1);
    idle(10);
    step(1'b1, 5'd26, 32'd1);
    check("dp_k", out_a(), pk(0, 0, 0, 0, 32'd12, 32'd0));
    idle(1);
    check("dp_k1", out_a(), pk(0, 0, 0, 0, 32'd13, 32'd0));
    idle(1);
    check("dp_pass", out_a(), pk(1, 1, 0, 0, 32'd14, 32'd0));
    idle(3);
    check("dp_frozen", out_a(), pk(1, 1, 0, 0, 32'd14, 32'd0));

    // Late result forwarded on the verdict edge
    do_reset();
    step(1'b1, 5'd27, 32'd0);
    step(1'b1, 5'd26, 32'd1);
    idle(1);
    check("late_k1", out_a(), pk(0, 0, 0, 0, 32'd3, 32'd0));
    step(1'b1, 5'd27, 32'd1);
    check("late_pass", out_a(), pk(1, 1, 0, 0, 32'd4, 32'd0));

    // Non-one done values keep running
    do_reset();
    step(1'b1, 5'd26, 32'd5);
    step(1'b1, 5'd26, 32'd0);
    idle(98);
    check("nonone_run", out_a(), pk(0, 0, 0, 0, 32'd100, 32'd0));

    // Timeout on the 50th edge
    do_reset();
    step(1'b1, 5'd3, 32'd4);
    idle(48);
    check("to_49", out_b(), pk(0, 0, 0, 0, 32'd49, 32'd0));
    idle(1);
    check("to_50", out_b(), pk(1, 0, 0, 1, 32'd50, 32'd4));
    step(1'b1, 5'd27, 32'd1);
    step(1'b1, 5'd26, 32'd1);
    step(1'b1, 5'd3, 32'd9);
    idle(3);
    check("to_sticky", out_b(), pk(1, 0, 0, 1, 32'd50, 32'd4));

    // Done write on the timeout edge wins
    do_reset();
    idle(49);
    step(1'b1, 5'd26, 32'd1);
    check("race_done50", out_b(), pk(0, 0, 0, 0, 32'd50, 32'd0));
    idle(1);
    check("race_done51", out_b(), pk(0, 0, 0, 0, 32'd51, 32'd0));
    idle(1);
    check("race_done52", out_b(), pk(1, 0, 1, 0, 32'd52, 32'd0));

    // Settle expiry on the timeout edge wins
    do_reset();
    step(1'b1, 5'd27, 32'd1);
    idle(46);
    step(1'b1, 5'd26, 32'd1);
    idle(2);
    check("race_settle", out_b(), pk(1, 1, 0, 0, 32'd50, 32'd0));

    // Reset during SETTLE
    do_reset();
    step(1'b1, 5'd27, 32'd1);
    step(1'b1, 5'd26, 32'd1);
    idle(1);
    rst = 1'b0;
    #2;
    check("midrst_a", out_a(), '0);
    check("midrst_b", out_b(), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    step(1'b1, 5'd26, 32'd1);
    idle(2);
    check("midrst_cleared", out_a(), pk(1, 0, 1, 0, 32'd3, 32'd0));
    do_reset();
    step(1'b1, 5'd0, 32'd5);
    step(1'b1, 5'd27, 32'd1);
    step(1'b1, 5'd26, 32'd1);
    step(1'b1, 5'd0, 32'd0);
    step(1'b1, 5'd0, 32'd1);
    check("fresh_pass", out_a(), pk(1, 1, 0, 0, 32'd5, 32'd0));

    // Randomized episodes against the reference model
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      len = int'($urandom_range(20, 90));
      for (int c = 0; c < len; c++) begin
        r  = int'($urandom_range(0, 9));
        re = 1'b1;
        ra = 5'd0;
        rd = $urandom;
        case (r)
          0, 1, 2: begin re = 1'b0; rd = '0; end
          3:       ra = 5'd0;
          4, 5:    begin ra = 5'd3; rd = 32'($urandom_range(0, 40)); end
          6, 7:    begin
                     ra = 5'd27;
                     rd = ($urandom_range(0, 2) != 0) ? 32'd1 : 32'($urandom_range(0, 3));
                   end
          8:       begin
                     ra = 5'd26;
                     rd = ($urandom_range(0, 3) == 0) ? 32'd1 : 32'($urandom_range(2, 6));
                   end
          default: ra = 5'($urandom_range(0, 31));
        endcase
        step(re, ra, rd);
        check("rand_a", out_a(), model_exp(0));
        check("rand_b", out_b(), model_exp(1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
